alu_issue_ctrl: RTL

Sequential issue/response controller on the driving side of the Simple_CPU `alu_32bit` interface. It accepts R-type ALU commands (MIPS funct, two operands, tag) over a valid/ready handshake and decodes funct into the 4-bit ALU operation. It drives the combinational ALU from registered outputs, captures `alu_result`/`zero` one cycle later, and returns them over a second valid/ready handshake. It sits between the CPU control path and `alu_32bit`, and replaces ad-hoc direct ALU driving.

---
 rtl/simple_cpu_pkg.sv | 25 ++
 rtl/alu_issue_ctrl_if.sv | 29 ++
 rtl/alu_funct_decode.sv | 29 ++
 rtl/alu_issue_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
// Shared Simple_CPU definitions: MIPS R-type funct codes, alu_32bit
// operation codes and the issue controller state encoding.
package simple_cpu_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and response handshake bundle between the CPU control path
// (master) and the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [5:0]       cmd_funct;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [1:0]       rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_funct, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_funct, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational MIPS funct -> alu_32bit operation decoder, shared with the
// main control unit. Unknown funct codes report legal=0 and op=AND.
module alu_funct_decode
    import simple_cpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] op,
    output logic       legal
);

    // Map each supported R-type funct onto its ALU operation code.
    always_comb begin
        op    = ALU_AND;
        legal = 1'b1;
        case (funct)
            FUNCT_ADD: op = ALU_ADD;
            FUNCT_SUB: op = ALU_SUB;
            FUNCT_AND: op = ALU_AND;
            FUNCT_OR:  op = ALU_OR;
            FUNCT_NOR: op = ALU_NOR;
            FUNCT_SLT: op = ALU_SLT;
            default: begin
                op    = ALU_AND;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/response controller. Accepts one R-type command at a time,
// drives alu_32bit from registers for one cycle, captures its result and
// zero flag, checks the flag for consistency and returns the response.
module alu_issue_ctrl
    import simple_cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    issue_state_t     state_r;
    logic             cmd_ready_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] alu_in1_r;
    logic [WIDTH-1:0] alu_in2_r;
    logic [3:0]       alu_op_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_zero_r;
    logic [1:0]       rsp_err_r;
    logic [TAG_W-1:0] rsp_tag_r;

    logic [3:0]       dec_op_s;
    logic             dec_legal_s;

    alu_funct_decode u_decode (
        .funct (bus.cmd_funct),
        .op    (dec_op_s),
        .legal (dec_legal_s)
    );

    // Command/response sequencing; every output is a register of this FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cmd_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            alu_in1_r    <= {WIDTH{1'b0}};
            alu_in2_r    <= {WIDTH{1'b0}};
            alu_op_r     <= 4'd0;
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 2'b00;
            rsp_tag_r    <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        alu_in1_r   <= bus.cmd_a;
                        alu_in2_r   <= bus.cmd_b;
                        rsp_tag_r   <= bus.cmd_tag;
                        cmd_ready_r <= 1'b0;
                        if (dec_legal_s) begin
                            alu_op_r <= dec_op_s;
                            state_r  <= ISSUE;
                        end else begin
                            // Illegal funct never reaches the ALU: the
                            // operation code keeps its previous value.
                            rsp_result_r <= {WIDTH{1'b0}};
                            rsp_zero_r   <= 1'b0;
                            rsp_err_r    <= 2'b01;
                            rsp_valid_r  <= 1'b1;
                            state_r      <= RESP;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    rsp_result_r <= alu_result;
                    rsp_zero_r   <= alu_zero;
                    rsp_err_r    <= {(alu_zero != (alu_result == {WIDTH{1'b0}})), 1'b0};
                    rsp_valid_r  <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.rsp_tag    = rsp_tag_r;
    assign alu_in1        = alu_in1_r;
    assign alu_in2        = alu_in2_r;
    assign alu_operation  = alu_op_r;

endmodule
